// File: rtl/instr_register_gen2_if.sv
// Bus bundle for instr_register_gen2: capture request, operands, pointers
// and the registered read-back port. The master drives requests, the slave
// (the register file) returns read-back data and its write pointer.
interface instr_register_gen2_if #(
  parameter int OPW   = 32,
  parameter int ADDRW = 5
);
  logic                    load_en;
  logic [3:0]              opcode;
  logic signed [OPW-1:0]   operand_a;
  logic signed [OPW-1:0]   operand_b;
  logic [ADDRW-1:0]        write_pointer;
  logic [ADDRW-1:0]        read_pointer;
  logic                    rd_en;
  logic [3:0]              iw_opcode;
  logic signed [OPW-1:0]   iw_op_a;
  logic signed [OPW-1:0]   iw_op_b;
  logic signed [2*OPW-1:0] iw_result;
  logic                    iw_valid;
  logic                    iw_err;
  logic [ADDRW-1:0]        wr_ptr_q;

  modport master (
    output load_en, opcode, operand_a, operand_b, write_pointer, read_pointer, rd_en,
    input  iw_opcode, iw_op_a, iw_op_b, iw_result, iw_valid, iw_err, wr_ptr_q
  );

  modport slave (
    input  load_en, opcode, operand_a, operand_b, write_pointer, read_pointer, rd_en,
    output iw_opcode, iw_op_a, iw_op_b, iw_result, iw_valid, iw_err, wr_ptr_q
  );
endinterface

// File: rtl/instr_register_gen2.sv
// Second-generation instruction register file. A load request is captured
// into stage 1, the result is computed from stage 1 and committed with its
// operands one edge later. Reads are registered and forward a commit that
// lands on the same address at the same edge (write-first).
module instr_register_gen2 #(
  parameter int DEPTH    = 32,
  parameter int OPW      = 32,
  parameter bit AUTO_INC = 1'b0
) (
  input logic                 clk,
  input logic                 reset_n,
  instr_register_gen2_if.slave bus
);
  localparam int ADDRW = $clog2(DEPTH);
  localparam int RW    = 2 * OPW;
  // Entry layout: {err, opcode, operand_a, operand_b, result}
  localparam int EW    = 1 + 4 + OPW + OPW + RW;

  // Signed ALU on sign-extended operands; returns {err, result}.
  // Division by zero yields 0 without error; opcodes 8..15 flag err.
  function automatic logic [RW:0] alu(input logic [3:0] op,
                                      input logic signed [OPW-1:0] a,
                                      input logic signed [OPW-1:0] b);
    logic signed [RW-1:0] ax;
    logic signed [RW-1:0] bx;
    logic signed [RW-1:0] r;
    logic                 e;
    ax = $signed({{OPW{a[OPW-1]}}, a});
    bx = $signed({{OPW{b[OPW-1]}}, b});
    r  = '0;
    e  = 1'b0;
    case (op)
      4'd0: r = '0;
      4'd1: r = ax;
      4'd2: r = bx;
      4'd3: r = ax + bx;
      4'd4: r = ax - bx;
      4'd5: r = ax * bx;
      4'd6: begin
        if (bx != '0) r = ax / bx;
        else          r = '0;
      end
      4'd7: begin
        if (bx != '0) r = ax % bx;
        else          r = '0;
      end
      default: begin
        r = '0;
        e = 1'b1;
      end
    endcase
    return {e, r};
  endfunction

  logic                  s1_vld_q, s1_vld_d;
  logic [3:0]            s1_op_q, s1_op_d;
  logic signed [OPW-1:0] s1_a_q, s1_a_d;
  logic signed [OPW-1:0] s1_b_q, s1_b_d;
  logic [ADDRW-1:0]      s1_addr_q, s1_addr_d;
  logic [ADDRW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [EW-1:0]         mem_q [DEPTH];
  logic [RW:0]           alu_s;
  logic [EW-1:0]         entry_s;
  logic [EW-1:0]         rd_entry_s;

  logic [3:0]            iw_opcode_q, iw_opcode_d;
  logic signed [OPW-1:0] iw_op_a_q, iw_op_a_d;
  logic signed [OPW-1:0] iw_op_b_q, iw_op_b_d;
  logic signed [RW-1:0]  iw_result_q, iw_result_d;
  logic                  iw_valid_q, iw_valid_d;
  logic                  iw_err_q, iw_err_d;

  // Stage-1 capture and write-pointer update on an accepted load.
  always_comb begin
    s1_vld_d  = 1'b0;
    s1_op_d   = s1_op_q;
    s1_a_d    = s1_a_q;
    s1_b_d    = s1_b_q;
    s1_addr_d = s1_addr_q;
    wr_ptr_d  = wr_ptr_q;
    if (bus.load_en) begin
      s1_vld_d  = 1'b1;
      s1_op_d   = bus.opcode;
      s1_a_d    = bus.operand_a;
      s1_b_d    = bus.operand_b;
      s1_addr_d = AUTO_INC ? wr_ptr_q : bus.write_pointer;
      wr_ptr_d  = AUTO_INC ? wr_ptr_q + ADDRW'(1) : bus.write_pointer;
    end else begin
      s1_vld_d  = 1'b0;
    end
  end

  // Commit data and per-entry valid bits for the stage-1 instruction.
  always_comb begin
    alu_s   = alu(s1_op_q, s1_a_q, s1_b_q);
    entry_s = {alu_s[RW], s1_op_q, s1_a_q, s1_b_q, alu_s[RW-1:0]};
    valid_d = valid_q;
    if (s1_vld_q) valid_d[s1_addr_q] = 1'b1;
    else          valid_d = valid_q;
  end

  // Read-back selection: forward a same-edge commit, zero invalid entries.
  always_comb begin
    rd_entry_s  = '0;
    iw_opcode_d = iw_opcode_q;
    iw_op_a_d   = iw_op_a_q;
    iw_op_b_d   = iw_op_b_q;
    iw_result_d = iw_result_q;
    iw_valid_d  = iw_valid_q;
    iw_err_d    = iw_err_q;
    if (bus.rd_en) begin
      if (s1_vld_q && (s1_addr_q == bus.read_pointer)) begin
        rd_entry_s = entry_s;
        iw_valid_d = 1'b1;
      end else if (valid_q[bus.read_pointer]) begin
        rd_entry_s = mem_q[bus.read_pointer];
        iw_valid_d = 1'b1;
      end else begin
        rd_entry_s = '0;
        iw_valid_d = 1'b0;
      end
      iw_err_d    = rd_entry_s[EW-1];
      iw_opcode_d = rd_entry_s[RW+2*OPW+3 -: 4];
      iw_op_a_d   = rd_entry_s[RW+2*OPW-1 -: OPW];
      iw_op_b_d   = rd_entry_s[RW+OPW-1 -: OPW];
      iw_result_d = rd_entry_s[RW-1:0];
    end else begin
      rd_entry_s = '0;
    end
  end

  // Control state: stage 1, write pointer, valid bits and read-back port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld_q    <= 1'b0;
      s1_op_q     <= 4'd0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_addr_q   <= '0;
      wr_ptr_q    <= '0;
      valid_q     <= '0;
      iw_opcode_q <= 4'd0;
      iw_op_a_q   <= '0;
      iw_op_b_q   <= '0;
      iw_result_q <= '0;
      iw_valid_q  <= 1'b0;
      iw_err_q    <= 1'b0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_addr_q   <= s1_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      valid_q     <= valid_d;
      iw_opcode_q <= iw_opcode_d;
      iw_op_a_q   <= iw_op_a_d;
      iw_op_b_q   <= iw_op_b_d;
      iw_result_q <= iw_result_d;
      iw_valid_q  <= iw_valid_d;
      iw_err_q    <= iw_err_d;
    end
  end

  // Entry storage; contents are qualified by valid_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (s1_vld_q) mem_q[s1_addr_q] <= entry_s;
  end

  assign bus.iw_opcode = iw_opcode_q;
  assign bus.iw_op_a   = iw_op_a_q;
  assign bus.iw_op_b   = iw_op_b_q;
  assign bus.iw_result = iw_result_q;
  assign bus.iw_valid  = iw_valid_q;
  assign bus.iw_err    = iw_err_q;
  assign bus.wr_ptr_q  = wr_ptr_q;
endmodule

// File: tb/tb_instr_register_gen2.sv
// Bench for instr_register_gen2: two instances (addressed, DEPTH=8 and
// auto-increment, DEPTH=4, both OPW=8) checked every cycle against an
// architectural model, plus hand-computed literal expectations.
module tb_instr_register_gen2;
  logic clk = 1'b0;
  logic reset_n;
  bit   chk_en = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  instr_register_gen2_if #(.OPW(8), .ADDRW(3)) if0 ();
  instr_register_gen2_if #(.OPW(8), .ADDRW(2)) if1 ();

  instr_register_gen2 #(.DEPTH(8), .OPW(8), .AUTO_INC(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0));
  instr_register_gen2 #(.DEPTH(4), .OPW(8), .AUTO_INC(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1));

  // Architectural model state, index k = instance
  int              dep [2] = '{8, 4};
  bit              ai  [2] = '{1'b0, 1'b1};
  bit              m_valid [2][8];
  logic [3:0]      m_op    [2][8];
  logic signed [7:0]  m_a  [2][8];
  logic signed [7:0]  m_b  [2][8];
  logic signed [15:0] m_res[2][8];
  bit              m_err   [2][8];
  bit              pv [2];
  int              p_addr [2];
  logic [3:0]      p_op [2];
  logic signed [7:0] p_a [2];
  logic signed [7:0] p_b [2];
  int              m_ptr [2];
  logic [3:0]      e_op [2];
  logic signed [7:0]  e_a [2];
  logic signed [7:0]  e_b [2];
  logic signed [15:0] e_res [2];
  bit              e_valid [2];
  bit              e_err [2];

  task automatic check(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Arithmetic from the opcode definitions using plain integers
  function automatic void calc(input logic [3:0] op, input int a, input int b,
                               output int r, output bit e);
    int q;
    r = 0; e = 1'b0;
    case (op)
      4'd0: r = 0;
      4'd1: r = a;
      4'd2: r = b;
      4'd3: r = a + b;
      4'd4: r = a - b;
      4'd5: r = a * b;
      4'd6, 4'd7: begin
        if (b != 0) begin
          q = (a < 0 ? -a : a) / (b < 0 ? -b : b);
          if ((a < 0) != (b < 0)) q = -q;
          r = (op == 4'd6) ? q : a - q * b;
        end
      end
      default: e = 1'b1;
    endcase
  endfunction

  task automatic model_reset(input int k);
    for (int i = 0; i < 8; i++) m_valid[k][i] = 1'b0;
    pv[k] = 1'b0; m_ptr[k] = 0;
    e_op[k] = 4'd0; e_a[k] = 8'sd0; e_b[k] = 8'sd0; e_res[k] = 16'sd0;
    e_valid[k] = 1'b0; e_err[k] = 1'b0;
  endtask

  // One clock edge: earlier load becomes visible, then read, then capture
  task automatic model_step(input int k, input logic ld, input logic [3:0] op,
                            input logic signed [7:0] a, input logic signed [7:0] b,
                            input int wp, input logic rd, input int rp);
    int r; bit e;
    if (pv[k]) begin
      calc(p_op[k], int'(p_a[k]), int'(p_b[k]), r, e);
      m_valid[k][p_addr[k]] = 1'b1;
      m_op[k][p_addr[k]] = p_op[k];
      m_a[k][p_addr[k]] = p_a[k];
      m_b[k][p_addr[k]] = p_b[k];
      m_res[k][p_addr[k]] = 16'(r);
      m_err[k][p_addr[k]] = e;
    end
    if (rd) begin
      e_valid[k] = m_valid[k][rp];
      e_op[k]  = m_valid[k][rp] ? m_op[k][rp] : 4'd0;
      e_a[k]   = m_valid[k][rp] ? m_a[k][rp] : 8'sd0;
      e_b[k]   = m_valid[k][rp] ? m_b[k][rp] : 8'sd0;
      e_res[k] = m_valid[k][rp] ? m_res[k][rp] : 16'sd0;
      e_err[k] = m_valid[k][rp] ? m_err[k][rp] : 1'b0;
    end
    pv[k] = ld;
    if (ld) begin
      p_addr[k] = ai[k] ? m_ptr[k] : wp;
      p_op[k] = op; p_a[k] = a; p_b[k] = b;
      m_ptr[k] = ai[k] ? (m_ptr[k] + 1) % dep[k] : wp;
    end
  endtask

  task automatic cmp(input int k, input logic [3:0] op, input logic signed [7:0] a,
                     input logic signed [7:0] b, input logic signed [15:0] r,
                     input logic v, input logic e, input logic [7:0] p);
    check($sformatf("u%0d_iw_opcode", k), {60'd0, op}, {60'd0, e_op[k]});
    check($sformatf("u%0d_iw_op_a", k), a, e_a[k]);
    check($sformatf("u%0d_iw_op_b", k), b, e_b[k]);
    check($sformatf("u%0d_iw_result", k), r, e_res[k]);
    check($sformatf("u%0d_iw_valid", k), {63'd0, v}, {63'd0, e_valid[k]});
    check($sformatf("u%0d_iw_err", k), {63'd0, e}, {63'd0, e_err[k]});
    check($sformatf("u%0d_wr_ptr_q", k), {56'd0, p}, 64'(m_ptr[k]));
  endtask

  // Model update on every edge, async clear on reset
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, if0.load_en, if0.opcode, if0.operand_a, if0.operand_b,
                 int'(if0.write_pointer), if0.rd_en, int'(if0.read_pointer));
      model_step(1, if1.load_en, if1.opcode, if1.operand_a, if1.operand_b,
                 int'(if1.write_pointer), if1.rd_en, int'(if1.read_pointer));
    end
  end

  // Per-cycle comparison away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, if0.iw_opcode, if0.iw_op_a, if0.iw_op_b, if0.iw_result,
          if0.iw_valid, if0.iw_err, {5'd0, if0.wr_ptr_q});
      cmp(1, if1.iw_opcode, if1.iw_op_a, if1.iw_op_b, if1.iw_result,
          if1.iw_valid, if1.iw_err, {6'd0, if1.wr_ptr_q});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load0(input logic [3:0] op, input logic signed [7:0] a,
                       input logic signed [7:0] b, input logic [2:0] wp);
    if0.load_en = 1'b1; if0.opcode = op;
    if0.operand_a = a; if0.operand_b = b; if0.write_pointer = wp;
  endtask

  task automatic read0(input logic [2:0] rp);
    if0.load_en = 1'b0; if0.rd_en = 1'b1; if0.read_pointer = rp;
    cyc();
  endtask

  int exp4 [4] = '{5, 6, 3, 4};

  initial begin
    if0.load_en = 1'b0; if0.opcode = 4'd0; if0.operand_a = 8'sd0; if0.operand_b = 8'sd0;
    if0.write_pointer = 3'd0; if0.read_pointer = 3'd0; if0.rd_en = 1'b0;
    if1.load_en = 1'b0; if1.opcode = 4'd0; if1.operand_a = 8'sd0; if1.operand_b = 8'sd0;
    if1.write_pointer = 2'd0; if1.read_pointer = 2'd0; if1.rd_en = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk_en = 1'b1;
    cyc();

    // 1: read of entry 0 after reset
    if0.rd_en = 1'b1; if0.read_pointer = 3'd0;
    if1.rd_en = 1'b1; if1.read_pointer = 2'd0;
    cyc();
    check("t1_valid", {63'd0, if0.iw_valid}, 64'sd0);
    check("t1_result", if0.iw_result, 64'sd0);
    if0.rd_en = 1'b0; if1.rd_en = 1'b0;

    // 2: ADD and MULT at addresses 3 and 4
    load0(4'd3, 8'sd100, 8'sd100, 3'd3); cyc();
    load0(4'd5, -8'sd128, -8'sd128, 3'd4); cyc();
    read0(3'd3);
    check("t2_add", if0.iw_result, 64'sd200);
    check("t2_add_valid", {63'd0, if0.iw_valid}, 64'sd1);
    check("t2_add_err", {63'd0, if0.iw_err}, 64'sd0);
    check("t2_model_add", e_res[0], 64'sd200);
    read0(3'd4);
    check("t2_mult", if0.iw_result, 64'sd16384);

    // 3: DIV/MOD rounding, divide by zero, illegal opcode
    load0(4'd6, -8'sd7, 8'sd2, 3'd0); cyc();
    load0(4'd7, -8'sd7, 8'sd2, 3'd1); cyc();
    load0(4'd6, 8'sd5, 8'sd0, 3'd2); cyc();
    load0(4'd9, 8'sd3, 8'sd4, 3'd6); cyc();
    read0(3'd0);
    check("t3_div", if0.iw_result, -64'sd3);
    read0(3'd1);
    check("t3_mod", if0.iw_result, -64'sd1);
    check("t3_model_mod", e_res[0], -64'sd1);
    read0(3'd2);
    check("t3_div0", if0.iw_result, 64'sd0);
    check("t3_div0_err", {63'd0, if0.iw_err}, 64'sd0);
    check("t3_div0_valid", {63'd0, if0.iw_valid}, 64'sd1);
    read0(3'd6);
    check("t3_illegal", if0.iw_result, 64'sd0);
    check("t3_illegal_err", {63'd0, if0.iw_err}, 64'sd1);
    if0.rd_en = 1'b0;

    // 4: auto-increment wrap over six loads
    for (int i = 1; i <= 6; i++) begin
      if1.load_en = 1'b1; if1.opcode = 4'd1;
      if1.operand_a = 8'(i); if1.operand_b = 8'sd0;
      cyc();
    end
    check("t4_wr_ptr", {62'd0, if1.wr_ptr_q}, 64'sd2);
    if1.load_en = 1'b0; if1.rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if1.read_pointer = 2'(i);
      cyc();
      check($sformatf("t4_entry%0d", i), if1.iw_result, 64'(exp4[i]));
    end
    if1.rd_en = 1'b0;

    // 5: write-first forwarding at address 5
    load0(4'd1, 8'sd11, 8'sd0, 3'd5); cyc();
    if0.load_en = 1'b0; cyc();
    load0(4'd2, 8'sd0, 8'sd22, 3'd5);
    if0.rd_en = 1'b1; if0.read_pointer = 3'd5;
    cyc();
    check("t5_prior", if0.iw_result, 64'sd11);
    read0(3'd5);
    check("t5_fwd", if0.iw_result, 64'sd22);
    check("t5_fwd_op", {60'd0, if0.iw_opcode}, 64'sd2);
    if0.rd_en = 1'b0;

    // 6: reset between capture and commit
    load0(4'd3, 8'sd1, 8'sd2, 3'd7); cyc();
    if0.load_en = 1'b0;
    reset_n = 1'b0;
    #1;
    check("t6_async_valid", {63'd0, if0.iw_valid}, 64'sd0);
    check("t6_async_result", if0.iw_result, 64'sd0);
    check("t6_async_ptr1", {62'd0, if1.wr_ptr_q}, 64'sd0);
    check("t6_async_ptr0", {61'd0, if0.wr_ptr_q}, 64'sd0);
    @(negedge clk);
    reset_n = 1'b1;
    if0.rd_en = 1'b1; if0.read_pointer = 3'd7;
    cyc();
    check("t6_discarded", {63'd0, if0.iw_valid}, 64'sd0);
    if0.rd_en = 1'b0;
    if1.load_en = 1'b1; if1.opcode = 4'd1; if1.operand_a = 8'sd9;
    cyc();
    if1.load_en = 1'b0; if1.rd_en = 1'b1; if1.read_pointer = 2'd0;
    cyc();
    check("t6_first_load", if1.iw_result, 64'sd9);
    if1.rd_en = 1'b0;
    repeat (2) cyc();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
